// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding instruction-memory read at a time,
// with a single-entry output buffer toward decode and redirect handling.
//
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   redirect, redirect_pc - load a new fetch word address (branch/jump/JR)
//   imem_req, imem_addr   - read request and its word address
//   imem_gnt              - memory accepted the request this cycle
//   imem_rvalid, imem_rdata - returned instruction word
//   id_valid, id_instr, id_pc, id_pc_plus1 - instruction offered to decode
//   id_ready              - decode accepts the offered instruction
module if_stage #(
    parameter logic [29:0] RESET_PC = 30'h0000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [29:0] redirect_pc,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [29:0] id_pc,
    output logic [29:0] id_pc_plus1,
    input  logic        id_ready
);

    localparam int unsigned AW = 30;
    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [AW-1:0] pc, pc_n;
    logic [AW-1:0] inflight, inflight_n;
    logic          drop, drop_n;
    logic [DW-1:0] instr_q, instr_n;
    logic [AW-1:0] idpc_q, idpc_n;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            inflight <= '0;
            drop     <= 1'b0;
            instr_q  <= '0;
            idpc_q   <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            inflight <= inflight_n;
            drop     <= drop_n;
            instr_q  <= instr_n;
            idpc_q   <= idpc_n;
        end
    end

    // Next-state, datapath updates and handshake outputs
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        inflight_n = inflight;
        drop_n     = drop;
        instr_n    = instr_q;
        idpc_n     = idpc_q;
        imem_req   = 1'b0;
        id_valid   = 1'b0;

        case (state)
            S_IDLE: begin
                state_n = S_REQ;
                if (redirect) pc_n = redirect_pc;
            end
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_gnt) begin
                    // Grant belongs to the address presented now, even if redirected
                    inflight_n = pc;
                    state_n    = S_WAIT;
                    if (redirect) begin
                        drop_n = 1'b1;
                        pc_n   = redirect_pc;
                    end
                end else if (redirect) begin
                    pc_n = redirect_pc;
                end
            end
            S_WAIT: begin
                if (redirect) pc_n = redirect_pc;
                if (imem_rvalid) begin
                    // Stale response (earlier or same-cycle redirect) is discarded
                    if (drop || redirect) begin
                        drop_n  = 1'b0;
                        state_n = S_REQ;
                    end else begin
                        instr_n = imem_rdata;
                        idpc_n  = inflight;
                        state_n = S_HOLD;
                    end
                end else if (redirect) begin
                    drop_n = 1'b1;
                end
            end
            S_HOLD: begin
                id_valid = ~redirect;
                if (redirect) begin
                    pc_n    = redirect_pc;
                    state_n = S_REQ;
                end else if (id_ready) begin
                    pc_n    = idpc_q + AW'(1);
                    state_n = S_REQ;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign imem_addr   = pc;
    assign id_instr    = instr_q;
    assign id_pc       = idpc_q;
    assign id_pc_plus1 = idpc_q + AW'(1);

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a per-cycle vector table for the directed
// corner cases plus a randomized-latency fetch sequence; returned instructions
// go through a scoreboard queue and are checked when decode sees them.
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic        redirect;
    logic [29:0] redirect_pc;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [29:0] id_pc;
    logic [29:0] id_pc_plus1;
    logic        id_ready;

    if_stage dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc_plus1 (id_pc_plus1),
        .id_ready    (id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        redir;
        logic [29:0] rpc;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        push;
        logic [29:0] push_pc;
        logic        drop_q;
        logic        e_req;
        logic [29:0] e_addr;
        logic        e_valid;
        logic        chk_zero;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [29:0] pc;
    } sb_t;

    vec_t tbl[$];
    sb_t  sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic v(input logic rst, input logic redir, input logic [29:0] rpc,
                     input logic gnt, input logic rv, input logic [31:0] rdata,
                     input logic rdy, input logic push, input logic [29:0] push_pc,
                     input logic drop_q, input logic e_req, input logic [29:0] e_addr,
                     input logic e_valid, input logic chk_zero);
        vec_t t;
        t.rst = rst; t.redir = redir; t.rpc = rpc; t.gnt = gnt; t.rv = rv;
        t.rdata = rdata; t.rdy = rdy; t.push = push; t.push_pc = push_pc;
        t.drop_q = drop_q; t.e_req = e_req; t.e_addr = e_addr;
        t.e_valid = e_valid; t.chk_zero = chk_zero;
        tbl.push_back(t);
    endtask

    task automatic clear_inputs();
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        id_ready    = 1'b0;
    endtask

    // Compare whatever decode is being offered against the scoreboard head
    task automatic check_out();
        sb_t e;
        if (id_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_id_valid", 32'(id_valid), 32'd0);
            end else begin
                e = sbq[0];
                chk("id_instr", id_instr, e.instr);
                chk("id_pc", 32'(id_pc), 32'(e.pc));
                chk("id_pc_plus1", 32'(id_pc_plus1), 32'(30'(e.pc + 30'd1)));
                if (id_ready) void'(sbq.pop_front());
            end
        end
    endtask

    // One fetch with random grant / response / accept delays
    task automatic fetch_one(input logic [29:0] exp_addr);
        int   n;
        bit   done;
        sb_t  e;
        logic [31:0] data;
        data = $urandom;
        n = 0; done = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            clear_inputs();
            imem_gnt = 1'($urandom_range(0, 1));
            #1;
            check_out();
            if (imem_req && imem_gnt) begin
                chk("rand_addr", 32'(imem_addr), 32'(exp_addr));
                done = 1;
            end
            n++;
        end
        if (!done) chk("grant_timeout", 32'd0, 32'd1);
        for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
            @(negedge clk);
            clear_inputs();
            #1;
            chk("wait_req_low", 32'(imem_req), 32'd0);
            chk("wait_valid_low", 32'(id_valid), 32'd0);
        end
        @(negedge clk);
        clear_inputs();
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        e.instr = data;
        e.pc    = exp_addr;
        sbq.push_back(e);
        #1;
        check_out();
        n = 0; done = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            clear_inputs();
            id_ready = 1'($urandom_range(0, 1));
            #1;
            chk("rand_valid", 32'(id_valid), 32'd1);
            chk("hold_req_low", 32'(imem_req), 32'd0);
            check_out();
            if (id_ready) done = 1;
            n++;
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        vec_t t;
        sb_t  e;
        clear_inputs();
        reset = 1'b1;

        //  rst rd rpc          gnt rv rdata         rdy push ppc          dq  req addr        val cz
        v(1, 0, 30'h0,        0, 0, 32'h0,        0, 0, 30'h0,        0, 0, 30'h0,        0, 1); // 0 reset
        v(0, 0, 30'h0,        0, 0, 32'h0,        0, 0, 30'h0,        0, 0, 30'h0,        0, 0); // 1 IDLE
        v(0, 0, 30'h0,        1, 0, 32'h0,        0, 0, 30'h0,        0, 1, 30'h0,        0, 0); // 2 REQ granted
        v(0, 0, 30'h0,        0, 1, 32'h8C220004, 0, 1, 30'h0,        0, 0, 30'h0,        0, 0); // 3 WAIT rvalid
        v(0, 0, 30'h0,        0, 0, 32'h0,        1, 0, 30'h0,        0, 0, 30'h0,        1, 0); // 4 HOLD accept
        v(0, 0, 30'h0,        0, 0, 32'h0,        0, 0, 30'h0,        0, 1, 30'h1,        0, 0); // 5 REQ addr 1
        v(0, 0, 30'h0,        1, 0, 32'h0,        0, 0, 30'h0,        0, 1, 30'h1,        0, 0); // 6 grant
        v(0, 0, 30'h0,        0, 1, 32'h11111111, 0, 1, 30'h1,        0, 0, 30'h0,        0, 0); // 7 rvalid
        for (int i = 0; i < 5; i++)
            v(0, 0, 30'h0,    0, 0, 32'h0,        0, 0, 30'h0,        0, 0, 30'h0,        1, 0); // 8-12 stall
        v(0, 0, 30'h0,        0, 0, 32'h0,        1, 0, 30'h0,        0, 0, 30'h0,        1, 0); // 13 accept
        v(0, 1, 30'h4,        0, 0, 32'h0,        0, 0, 30'h0,        0, 1, 30'h2,        0, 0); // 14 redirect ungranted
        v(0, 0, 30'h0,        1, 0, 32'h0,        0, 0, 30'h0,        0, 1, 30'h4,        0, 0); // 15 grant addr 4
        v(0, 1, 30'h100,      0, 1, 32'hDEADBEEF, 0, 0, 30'h0,        0, 0, 30'h0,        0, 0); // 16 redirect+rvalid in WAIT
        v(0, 0, 30'h0,        1, 0, 32'h0,        0, 0, 30'h0,        0, 1, 30'h100,      0, 0); // 17 grant 0x100
        v(0, 0, 30'h0,        0, 1, 32'h22222222, 0, 1, 30'h100,      0, 0, 30'h0,        0, 0); // 18 rvalid
        v(0, 1, 30'h20,       0, 0, 32'h0,        1, 0, 30'h0,        1, 0, 30'h0,        0, 0); // 19 redirect in HOLD
        v(0, 1, 30'h3FFFFFFF, 1, 0, 32'h0,        0, 0, 30'h0,        0, 1, 30'h20,       0, 0); // 20 redirect with grant
        v(0, 0, 30'h0,        0, 1, 32'h33333333, 0, 0, 30'h0,        0, 0, 30'h0,        0, 0); // 21 dropped
        v(0, 0, 30'h0,        1, 0, 32'h0,        0, 0, 30'h0,        0, 1, 30'h3FFFFFFF, 0, 0); // 22 grant top
        v(0, 0, 30'h0,        1, 0, 32'h0,        0, 0, 30'h0,        0, 0, 30'h0,        0, 0); // 23 stray gnt in WAIT
        v(0, 0, 30'h0,        0, 1, 32'h44444444, 0, 1, 30'h3FFFFFFF, 0, 0, 30'h0,        0, 0); // 24 rvalid
        v(0, 0, 30'h0,        0, 0, 32'h0,        1, 0, 30'h0,        0, 0, 30'h0,        1, 0); // 25 accept, wrap
        v(0, 0, 30'h0,        1, 0, 32'h0,        0, 0, 30'h0,        0, 1, 30'h0,        0, 0); // 26 wrapped addr
        v(0, 1, 30'h50,       0, 0, 32'h0,        0, 0, 30'h0,        0, 0, 30'h0,        0, 0); // 27 redirect in WAIT
        v(0, 0, 30'h0,        0, 1, 32'h55555555, 0, 0, 30'h0,        0, 0, 30'h0,        0, 0); // 28 dropped later
        v(0, 0, 30'h0,        1, 0, 32'h0,        0, 0, 30'h0,        0, 1, 30'h50,       0, 0); // 29 grant 0x50
        v(1, 0, 30'h0,        0, 0, 32'h0,        0, 0, 30'h0,        0, 0, 30'h0,        0, 1); // 30 reset in WAIT
        v(0, 0, 30'h0,        0, 1, 32'h66666666, 0, 0, 30'h0,        0, 0, 30'h0,        0, 0); // 31 stray rvalid IDLE
        v(0, 0, 30'h0,        0, 1, 32'h77777777, 0, 0, 30'h0,        0, 1, 30'h0,        0, 0); // 32 stray rvalid REQ
        v(0, 0, 30'h0,        1, 0, 32'h0,        0, 0, 30'h0,        0, 1, 30'h0,        0, 0); // 33 grant
        v(0, 0, 30'h0,        0, 1, 32'h88888888, 0, 1, 30'h0,        0, 0, 30'h0,        0, 0); // 34 rvalid
        v(0, 0, 30'h0,        0, 0, 32'h0,        1, 0, 30'h0,        0, 0, 30'h0,        1, 0); // 35 accept

        for (int r = 0; r < tbl.size(); r++) begin
            t = tbl[r];
            @(negedge clk);
            reset       = t.rst;
            redirect    = t.redir;
            redirect_pc = t.rpc;
            imem_gnt    = t.gnt;
            imem_rvalid = t.rv;
            imem_rdata  = t.rdata;
            id_ready    = t.rdy;
            if (t.push) begin
                e.instr = t.rdata;
                e.pc    = t.push_pc;
                sbq.push_back(e);
            end
            #1;
            chk($sformatf("row%0d_req", r), 32'(imem_req), 32'(t.e_req));
            if (t.e_req) chk($sformatf("row%0d_addr", r), 32'(imem_addr), 32'(t.e_addr));
            chk($sformatf("row%0d_valid", r), 32'(id_valid), 32'(t.e_valid));
            if (t.chk_zero) begin
                chk($sformatf("row%0d_rst_addr", r), 32'(imem_addr), 32'h0);
                chk($sformatf("row%0d_rst_instr", r), id_instr, 32'h0);
                chk($sformatf("row%0d_rst_pc", r), 32'(id_pc), 32'h0);
            end
            check_out();
            if (t.drop_q && sbq.size() > 0) void'(sbq.pop_front());
        end

        for (int k = 0; k < 6; k++) fetch_one(30'(k + 1));

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute guard so the run always ends
    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
